// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch mode controller.
package stopwatch_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_ADJ_MIN = 2'd2,
        ST_ADJ_SEC = 2'd3
    } state_t;

    // Single-cycle commands sent to the minutes/seconds counter.
    typedef struct packed {
        logic cnt_step;
        logic min_step;
        logic sec_step;
        logic cnt_clr;
    } cmd_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board inputs and counter/display commands of the stopwatch controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               btn_pause;
    logic               btn_rst;
    logic               sw_adj;
    logic               sw_sel;
    logic               cnt_step;
    logic               min_step;
    logic               sec_step;
    logic               cnt_clr;
    logic               blink;
    logic [STATE_W-1:0] state;

    modport master (
        output btn_pause, btn_rst, sw_adj, sw_sel,
        input  cnt_step, min_step, sec_step, cnt_clr, blink, state
    );

    modport slave (
        input  btn_pause, btn_rst, sw_adj, sw_sel,
        output cnt_step, min_step, sec_step, cnt_clr, blink, state
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability debounce, rising-edge press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_q <= level;
            press   <= level & ~level_q;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: input conditioning, 1 Hz / 2 Hz tick divider and mode FSM.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned HALF  = CLK_HZ / 2;
    localparam int unsigned DIV_W = (HALF > 2) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             phase;
    logic             tick2_c;
    logic             tick1_c;
    logic             pause_p;
    logic             clr_p;
    logic             adj_m;
    logic             adj_s;
    logic             sel_m;
    logic             sel_s;
    state_t           state_q;
    state_t           state_n;
    cmd_t             cmd_q;
    cmd_t             cmd_n;
    logic             blink_q;
    logic             blink_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_pause),
        .press (pause_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_rst),
        .press (clr_p)
    );

    // Switches are level controls, so a plain 2-FF synchroniser suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            adj_m <= 1'b0;
            adj_s <= 1'b0;
            sel_m <= 1'b0;
            sel_s <= 1'b0;
        end else begin
            adj_m <= bus.sw_adj;
            adj_s <= adj_m;
            sel_m <= bus.sw_sel;
            sel_s <= sel_m;
        end
    end

    assign tick2_c = (div_cnt == DIV_W'(HALF - 1));
    assign tick1_c = tick2_c & phase;

    // Half-second divider; a clear realigns it so the first second is a full one.
    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick2_c) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // State and registered command/blink outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cmd_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cmd_q   <= cmd_n;
            blink_q <= blink_n;
        end
    end

    // Next state and commands; a step is issued only on cycles with no transition.
    always_comb begin
        state_n = state_q;
        cmd_n   = '0;
        blink_n = 1'b0;
        if (clr_p) begin
            state_n       = ST_RUN;
            cmd_n.cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (adj_s) begin
                        state_n = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                    end else if (pause_p) begin
                        state_n = ST_PAUSED;
                    end else begin
                        cmd_n.cnt_step = tick1_c;
                    end
                end
                ST_PAUSED: begin
                    if (pause_p) begin
                        state_n = ST_RUN;
                    end
                end
                ST_ADJ_MIN, ST_ADJ_SEC: begin
                    if (!adj_s) begin
                        state_n = ST_RUN;
                    end else if (pause_p) begin
                        state_n = ST_PAUSED;
                    end else if (sel_s != (state_q == ST_ADJ_SEC)) begin
                        state_n = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                        blink_n = blink_q ^ tick2_c;
                    end else begin
                        blink_n        = blink_q ^ tick2_c;
                        cmd_n.min_step = tick2_c & (state_q == ST_ADJ_MIN);
                        cmd_n.sec_step = tick2_c & (state_q == ST_ADJ_SEC);
                    end
                end
                default: state_n = ST_RUN;
            endcase
        end
    end

    assign bus.cnt_step = cmd_q.cnt_step;
    assign bus.min_step = cmd_q.min_step;
    assign bus.sec_step = cmd_q.sec_step;
    assign bus.cnt_clr  = cmd_q.cnt_clr;
    assign bus.blink    = blink_q;
    assign bus.state    = state_q;

endmodule
